// File: rtl/riscv_defines.sv
// Shared core definitions: datapath widths, memory access sizes and the
// memory-stage FSM state type.
package riscv_defines;

    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StWaitGnt,
        StWaitRvalid
    } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store alignment: byte enables, store-data replication,
// load-data extraction/extension and misalignment detection.
module lsu_align
    import riscv_defines::*;
(
    input  logic [1:0]            offset_i,
    input  logic [1:0]            size_i,
    input  logic                  is_unsigned_i,
    input  logic [WORD_WIDTH-1:0] store_data_i,
    input  logic [WORD_WIDTH-1:0] rdata_i,
    output logic [3:0]            be_o,
    output logic [WORD_WIDTH-1:0] wdata_o,
    output logic [WORD_WIDTH-1:0] load_data_o,
    output logic                  misaligned_o
);

    logic [WORD_WIDTH-1:0] shifted;
    logic                  sign;

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = store_data_i;
        misaligned_o = 1'b0;
        // Size 11 is illegal and falls through to word handling.
        case (size_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            MEM_HALF: begin
                be_o         = 4'b0011 << {offset_i[1], 1'b0};
                wdata_o      = {2{store_data_i[15:0]}};
                misaligned_o = offset_i[0];
            end
            default: begin
                be_o         = 4'b1111;
                wdata_o      = store_data_i;
                misaligned_o = |offset_i;
            end
        endcase
    end

    always_comb begin
        shifted     = rdata_i >> {offset_i, 3'b000};
        sign        = 1'b0;
        load_data_o = shifted;
        case (size_i)
            MEM_BYTE: begin
                sign        = shifted[7] & ~is_unsigned_i;
                load_data_o = {{24{sign}}, shifted[7:0]};
            end
            MEM_HALF: begin
                sign        = shifted[15] & ~is_unsigned_i;
                load_data_o = {{16{sign}}, shifted[15:0]};
            end
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: runs req/gnt/rvalid data-memory transactions, stalls
// upstream while one is outstanding, and registers results toward writeback.
module mem_stage
    import riscv_defines::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [WORD_WIDTH-1:0] ex_data_i,
    input  logic [WORD_WIDTH-1:0] store_data_i,
    input  logic [ADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    output logic                  stall_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [WORD_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [WORD_WIDTH-1:0] data_wdata_o,
    input  logic [WORD_WIDTH-1:0] data_rdata_i,
    output logic [WORD_WIDTH-1:0] wb_data_o,
    output logic [ADDR_WIDTH-1:0] reg_waddr_o,
    output logic                  reg_we_o,
    output logic                  valid_o,
    output logic                  misaligned_o
);

    mem_state_t            state_q;

    logic [WORD_WIDTH-1:0] req_addr_q;
    logic [1:0]            req_size_q;
    logic                  req_unsigned_q;
    logic [ADDR_WIDTH-1:0] req_waddr_q;
    logic                  req_we_q;
    logic [WORD_WIDTH-1:0] req_sdata_q;
    logic                  req_store_q;

    logic [WORD_WIDTH-1:0] wb_data_q;
    logic [ADDR_WIDTH-1:0] reg_waddr_q;
    logic                  reg_we_q;
    logic                  valid_q;
    logic                  misaligned_q;

    logic                  is_idle;
    logic                  memop;
    logic                  launch;
    logic [WORD_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_size;
    logic                  sel_unsigned;
    logic [WORD_WIDTH-1:0] sel_sdata;
    logic                  sel_store;
    logic [3:0]            align_be;
    logic [WORD_WIDTH-1:0] align_wdata;
    logic [WORD_WIDTH-1:0] align_load;
    logic                  align_misaligned;

    assign is_idle = (state_q == StIdle);
    assign memop   = mem_read_i | mem_write_i;

    // Alignment works on live inputs in IDLE and on the latched request after.
    assign sel_addr     = is_idle ? ex_data_i      : req_addr_q;
    assign sel_size     = is_idle ? mem_size_i     : req_size_q;
    assign sel_unsigned = is_idle ? mem_unsigned_i : req_unsigned_q;
    assign sel_sdata    = is_idle ? store_data_i   : req_sdata_q;
    assign sel_store    = is_idle ? mem_write_i    : req_store_q;

    lsu_align u_lsu_align (
        .offset_i      (sel_addr[1:0]),
        .size_i        (sel_size),
        .is_unsigned_i (sel_unsigned),
        .store_data_i  (sel_sdata),
        .rdata_i       (data_rdata_i),
        .be_o          (align_be),
        .wdata_o       (align_wdata),
        .load_data_o   (align_load),
        .misaligned_o  (align_misaligned)
    );

    assign launch = is_idle & valid_i & memop & ~align_misaligned;

    // Gating with rst_n keeps the combinational launch path quiet during reset.
    assign data_req_o   = rst_n & (launch | (state_q == StWaitGnt));
    assign stall_o      = rst_n & (launch | (state_q == StWaitGnt) |
                                   ((state_q == StWaitRvalid) & ~data_rvalid_i));
    assign data_addr_o  = data_req_o ? {sel_addr[WORD_WIDTH-1:2], 2'b00} : '0;
    assign data_we_o    = data_req_o & sel_store;
    assign data_be_o    = data_req_o ? align_be : 4'b0000;
    assign data_wdata_o = data_req_o ? align_wdata : '0;

    assign wb_data_o    = wb_data_q;
    assign reg_waddr_o  = reg_waddr_q;
    assign reg_we_o     = reg_we_q;
    assign valid_o      = valid_q;
    assign misaligned_o = misaligned_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            req_addr_q     <= '0;
            req_size_q     <= 2'b00;
            req_unsigned_q <= 1'b0;
            req_waddr_q    <= '0;
            req_we_q       <= 1'b0;
            req_sdata_q    <= '0;
            req_store_q    <= 1'b0;
            wb_data_q      <= '0;
            reg_waddr_q    <= '0;
            reg_we_q       <= 1'b0;
            valid_q        <= 1'b0;
            misaligned_q   <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (valid_i) begin
                        if (!memop) begin
                            wb_data_q   <= ex_data_i;
                            reg_waddr_q <= reg_waddr_i;
                            reg_we_q    <= reg_we_i;
                            valid_q     <= 1'b1;
                        end else if (align_misaligned) begin
                            wb_data_q    <= '0;
                            reg_waddr_q  <= reg_waddr_i;
                            reg_we_q     <= 1'b0;
                            valid_q      <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            req_addr_q     <= ex_data_i;
                            req_size_q     <= mem_size_i;
                            req_unsigned_q <= mem_unsigned_i;
                            req_waddr_q    <= reg_waddr_i;
                            req_we_q       <= reg_we_i;
                            req_sdata_q    <= store_data_i;
                            req_store_q    <= mem_write_i;
                            state_q        <= data_gnt_i ? StWaitRvalid : StWaitGnt;
                        end
                    end
                end
                StWaitGnt: begin
                    if (data_gnt_i) begin
                        state_q <= StWaitRvalid;
                    end
                end
                StWaitRvalid: begin
                    if (data_rvalid_i) begin
                        wb_data_q   <= req_store_q ? '0 : align_load;
                        reg_waddr_q <= req_waddr_q;
                        reg_we_q    <= ~req_store_q & req_we_q;
                        valid_q     <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] ex_data_i;
    logic [31:0] store_data_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic        stall_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic [31:0] wb_data_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic        valid_o;
    logic        misaligned_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_i        (valid_i),
        .ex_data_i      (ex_data_i),
        .store_data_i   (store_data_i),
        .reg_waddr_i    (reg_waddr_i),
        .reg_we_i       (reg_we_i),
        .mem_read_i     (mem_read_i),
        .mem_write_i    (mem_write_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .stall_o        (stall_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_addr_o    (data_addr_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_wdata_o   (data_wdata_o),
        .data_rdata_i   (data_rdata_i),
        .wb_data_o      (wb_data_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_we_o       (reg_we_o),
        .valid_o        (valid_o),
        .misaligned_o   (misaligned_o)
    );

    task automatic clear_inputs();
        valid_i        = 1'b0;
        ex_data_i      = '0;
        store_data_i   = '0;
        reg_waddr_i    = '0;
        reg_we_i       = 1'b0;
        mem_read_i     = 1'b0;
        mem_write_i    = 1'b0;
        mem_size_i     = 2'b00;
        mem_unsigned_i = 1'b0;
        data_gnt_i     = 1'b0;
        data_rvalid_i  = 1'b0;
        data_rdata_i   = '0;
    endtask

    task automatic set_mem(input logic rd, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] waddr, input logic [31:0] sdata);
        valid_i        = 1'b1;
        mem_read_i     = rd;
        mem_write_i    = ~rd;
        ex_data_i      = addr;
        mem_size_i     = size;
        mem_unsigned_i = uns;
        reg_waddr_i    = waddr;
        reg_we_i       = rd;
        store_data_i   = sdata;
    endtask

    task automatic test_reset();
        logic [99:0] all_out;
        clear_inputs();
        rst_n = 1'b0;
        #12;
        all_out = {stall_o, data_req_o, data_addr_o, data_we_o, data_be_o, wb_data_o,
                   reg_waddr_o, reg_we_o, valid_o, misaligned_o};
        checks++;
        if (all_out !== 100'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        valid_i = 1'b1; ex_data_i = 32'h0000_1234; reg_waddr_i = 5'd5; reg_we_i = 1'b1;
        #1;
        checks++;
        if ({stall_o, data_req_o} !== 2'b00) begin
            errors++;
            $display("FAIL add_no_stall_req: got %b want 00", {stall_o, data_req_o});
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if ({valid_o, wb_data_o, reg_waddr_o, reg_we_o} !== {1'b1, 32'h1234, 5'd5, 1'b1}) begin
            errors++;
            $display("FAIL add_result: got v=%b d=%h rd=%0d we=%b want v=1 d=1234 rd=5 we=1",
                     valid_o, wb_data_o, reg_waddr_o, reg_we_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL add_bubble: got valid_o=%b want 0", valid_o);
        end
    endtask

    // Load with grant in the launch cycle and rvalid one cycle later.
    task automatic run_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_wb, input logic [31:0] exp_addr);
        @(negedge clk);
        set_mem(1'b1, addr, size, uns, 5'd7, 32'h0);
        data_gnt_i = 1'b1;
        #1;
        checks++;
        if ({data_req_o, stall_o, data_we_o, data_addr_o, data_be_o} !==
            {1'b1, 1'b1, 1'b0, exp_addr, exp_be}) begin
            errors++;
            $display("FAIL %s_launch: got req=%b stall=%b we=%b addr=%h be=%b want 1 1 0 %h %b",
                     name, data_req_o, stall_o, data_we_o, data_addr_o, data_be_o,
                     exp_addr, exp_be);
        end
        @(negedge clk);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rdata;
        #1;
        checks++;
        if ({data_req_o, stall_o, valid_o} !== 3'b000) begin
            errors++;
            $display("FAIL %s_rvalid_cycle: got req=%b stall=%b valid=%b want 000",
                     name, data_req_o, stall_o, valid_o);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if ({valid_o, wb_data_o, reg_waddr_o, reg_we_o} !== {1'b1, exp_wb, 5'd7, 1'b1}) begin
            errors++;
            $display("FAIL %s_result: got v=%b d=%h rd=%0d we=%b want v=1 d=%h rd=7 we=1",
                     name, valid_o, wb_data_o, reg_waddr_o, reg_we_o, exp_wb);
        end
    endtask

    task automatic test_loads();
        run_load("lb", 32'h103, 2'b00, 1'b0, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80, 32'h100);
        run_load("lhu", 32'h202, 2'b01, 1'b1, 32'h8001_0000, 4'b1100, 32'h0000_8001, 32'h200);
        run_load("lh", 32'h200, 2'b01, 1'b0, 32'h1234_9ABC, 4'b0011, 32'hFFFF_9ABC, 32'h200);
        run_load("lw", 32'h700, 2'b10, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h700);
    endtask

    task automatic test_store_delayed_gnt();
        @(negedge clk);
        set_mem(1'b0, 32'h301, 2'b00, 1'b0, 5'd9, 32'h1234_56AB);
        reg_we_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                ex_data_i = 32'hFFF;   // request register must hold the address
                store_data_i = 32'h0;
            end
            data_gnt_i = (i == 3);
            data_rvalid_i = (i == 1);  // stray response while waiting for grant
            #1;
            checks++;
            if ({data_req_o, stall_o, data_we_o, data_addr_o, data_be_o, data_wdata_o} !==
                {1'b1, 1'b1, 1'b1, 32'h300, 4'b0010, 32'hABAB_ABAB}) begin
                errors++;
                $display("FAIL sb_req_cycle%0d: got req=%b stall=%b we=%b addr=%h be=%b wd=%h",
                         i, data_req_o, stall_o, data_we_o, data_addr_o, data_be_o,
                         data_wdata_o);
            end
        end
        @(negedge clk);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1;
        #1;
        checks++;
        if ({data_req_o, stall_o} !== 2'b00) begin
            errors++;
            $display("FAIL sb_rvalid_cycle: got req=%b stall=%b want 00", data_req_o, stall_o);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if ({valid_o, wb_data_o, reg_we_o} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL sb_result: got v=%b d=%h we=%b want v=1 d=0 we=0",
                     valid_o, wb_data_o, reg_we_o);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        set_mem(1'b1, 32'h402, 2'b10, 1'b0, 5'd3, 32'h0);
        data_gnt_i = 1'b1;
        #1;
        checks++;
        if ({data_req_o, stall_o} !== 2'b00) begin
            errors++;
            $display("FAIL mis_no_req: got req=%b stall=%b want 00", data_req_o, stall_o);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if ({misaligned_o, valid_o, reg_we_o} !== 3'b110) begin
            errors++;
            $display("FAIL mis_pulse: got mis=%b v=%b we=%b want 110",
                     misaligned_o, valid_o, reg_we_o);
        end
        @(negedge clk);
        checks++;
        if ({misaligned_o, valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL mis_one_cycle: got mis=%b v=%b want 00", misaligned_o, valid_o);
        end
        // Misaligned half also issues nothing.
        set_mem(1'b1, 32'h405, 2'b01, 1'b0, 5'd3, 32'h0);
        #1;
        checks++;
        if ({data_req_o, stall_o} !== 2'b00) begin
            errors++;
            $display("FAIL mis_half_no_req: got req=%b stall=%b", data_req_o, stall_o);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if (misaligned_o !== 1'b1) begin
            errors++;
            $display("FAIL mis_half_pulse: got mis=%b want 1", misaligned_o);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_mem(1'b1, 32'h600, 2'b10, 1'b0, 5'd11, 32'h0);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_0001;
        @(negedge clk);
        clear_inputs();
        valid_i = 1'b1; ex_data_i = 32'h55; reg_waddr_i = 5'd12; reg_we_i = 1'b1;
        #1;
        checks++;
        if ({valid_o, wb_data_o, reg_waddr_o, stall_o} !== {1'b1, 32'hCAFE_0001, 5'd11, 1'b0})
        begin
            errors++;
            $display("FAIL b2b_load: got v=%b d=%h rd=%0d stall=%b", valid_o, wb_data_o,
                     reg_waddr_o, stall_o);
        end
        @(negedge clk);
        clear_inputs();
        checks++;
        if ({valid_o, wb_data_o, reg_waddr_o} !== {1'b1, 32'h55, 5'd12}) begin
            errors++;
            $display("FAIL b2b_add: got v=%b d=%h rd=%0d want 1 55 12",
                     valid_o, wb_data_o, reg_waddr_o);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_mem(1'b1, 32'h500, 2'b10, 1'b0, 5'd4, 32'h0);
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_waiting: got stall=%b want 1", stall_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall_o, data_req_o, valid_o, wb_data_o, reg_we_o} !== 36'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got stall=%b req=%b v=%b d=%h we=%b want 0",
                     stall_o, data_req_o, valid_o, wb_data_o, reg_we_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_2222;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        checks++;
        if ({valid_o, stall_o} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_stray_rvalid: got v=%b stall=%b want 00", valid_o, stall_o);
        end
        valid_i = 1'b1; ex_data_i = 32'h77; reg_waddr_i = 5'd6; reg_we_i = 1'b1;
        @(negedge clk);
        clear_inputs();
        checks++;
        if ({valid_o, wb_data_o, reg_waddr_o, reg_we_o} !== {1'b1, 32'h77, 5'd6, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_add: got v=%b d=%h rd=%0d we=%b want 1 77 6 1",
                     valid_o, wb_data_o, reg_waddr_o, reg_we_o);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_loads();
        test_store_delayed_gnt();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth pipeline stage of the core, directly downstream of the execute stage. It takes the execute result (address or writeback value), store data and destination register, runs load/store transactions on the data-memory port with a req/gnt/rvalid handshake, and aligns and extends load data. It stalls the upstream stages while a transaction is outstanding and registers the result toward writeback.

## Interface
- Parameters, all from `riscv_defines`:
  - WORD_WIDTH, 32: datapath width.
  - ADDR_WIDTH, 5: register-file address width.
- Ports:
  - clk  in  1  core clock; everything is rising-edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - valid_i  in  1  execute presents a valid instruction.
  - ex_data_i  in  WORD_WIDTH  execute result; the byte address for loads and stores.
  - store_data_i  in  WORD_WIDTH  rs2 value for stores.
  - reg_waddr_i  in  ADDR_WIDTH  destination register.
  - reg_we_i  in  1  instruction writes rd.
  - mem_read_i, mem_write_i  in  1 each  load / store; never both high.
  - mem_size_i  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as word.
  - mem_unsigned_i  in  1  zero-extend loads (LBU/LHU).
  - stall_o  out  1  upstream must hold its outputs.
  - data_req_o  out  1  memory request.
  - data_gnt_i  in  1  request accepted.
  - data_rvalid_i  in  1  response valid, for loads and stores.
  - data_addr_o  out  WORD_WIDTH  word-aligned address (ex_data[31:2], 2'b00).
  - data_we_o  out  1  store.
  - data_be_o  out  4  byte enables.
  - data_wdata_o  out  WORD_WIDTH  replicated store data.
  - data_rdata_i  in  WORD_WIDTH  load data.
  - wb_data_o  out  WORD_WIDTH  result to writeback.
  - reg_waddr_o  out  ADDR_WIDTH  registered destination register.
  - reg_we_o  out  1  registered write enable.
  - valid_o  out  1  writeback result valid.
  - misaligned_o  out  1  one-cycle pulse for a misaligned access.

## Operation
- **FSM states:** IDLE, WAIT_GNT, WAIT_RVALID. Reset state is IDLE.
- **IDLE, non-memory instruction** (valid_i with neither mem_read_i nor mem_write_i): the output register loads ex_data_i, reg_waddr_i and reg_we_i, and valid_o is high for the next cycle. No stall.
- **IDLE, memory instruction:**
  - Address, size, unsigned, rd, store data and op are latched into a request register.
  - data_req_o is driven combinationally from the inputs in the same cycle.
  - If data_gnt_i is high in that cycle, go to WAIT_RVALID; otherwise go to WAIT_GNT.
- **WAIT_GNT:** data_req_o stays high with data_addr_o, data_we_o, data_be_o and data_wdata_o driven from the request register and held stable. Go to WAIT_RVALID on data_gnt_i.
- **WAIT_RVALID:** data_req_o is low. On data_rvalid_i:
  - The output register loads the result. Loads take the aligned, extended data with reg_we_o = latched reg_we. Stores take wb_data_o = 0 with reg_we_o = 0.
  - valid_o goes high for the next cycle and the FSM returns to IDLE.
- **Misaligned access** (half with addr[0] = 1, or word with addr[1:0] ≠ 0): no request is issued. misaligned_o is registered high for one cycle, with valid_o = 1 and reg_we_o = 0 in that same cycle. There is no stall.
- **Byte enables:**
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1], 0}
  - word: 1111
- **Store data:** byte → {4{d[7:0]}}, half → {2{d[15:0]}}, word → d.
- **Load data:** shift data_rdata_i right by 8 × addr[1:0], then take bit 7 (byte) or bit 15 (half) as the sign. Zero-extend when mem_unsigned_i is high.
- **Stall:** stall_o = (IDLE & valid_i & memop & aligned) | (WAIT_GNT) | (WAIT_RVALID & !data_rvalid_i).
- **Inputs ignored outside IDLE:** execute holds its outputs while stalled, so a held instruction is never relaunched.
- **Bubbles:** valid_o is 0 on any cycle with no completion.

## Timing
- **Reset values:** every output is 0, including data_req_o, stall_o, valid_o and misaligned_o. The request and output registers clear.
- **Latency:**
  - Non-memory instruction: 1 cycle.
  - Memory instruction with gnt in the launch cycle and rvalid one cycle later: 2 cycles, and stall_o is high for exactly 1 cycle.
  - Each extra gnt or rvalid wait cycle adds 1.
- **Back-to-back:** with stall_o low in the rvalid cycle, the next instruction is accepted in the following cycle in IDLE.
- **Stray responses:** data_rvalid_i in IDLE or WAIT_GNT is ignored.
- **Reset mid-transaction:** the FSM returns to IDLE immediately and data_req_o drops asynchronously. Any later rvalid is ignored.

## Structure
- Add to `riscv_defines`:
  - the mem_size encodings MEM_BYTE, MEM_HALF, MEM_WORD;
  - the `mem_state_t` enum typedef.
- Sub-module `lsu_align`: purely combinational. It computes byte enables, store replication, load extraction/extension and the misaligned flag. mem_stage keeps the FSM and registers.

## Test plan
- ADD result 0x0000_1234, rd = 5, we = 1 → next cycle valid_o = 1, wb_data_o = 0x1234, reg_waddr_o = 5, no stall, no req.
- LB at 0x103, rdata = 0x80FF_0000, gnt same cycle, rvalid next → data_addr_o = 0x100, be = 1000, wb_data_o = 0xFFFF_FF80, stall_o high 1 cycle.
- LHU at 0x202, rdata = 0x8001_0000 → wb_data_o = 0x0000_8001.
- SB 0xAB at 0x301, gnt delayed 3 cycles → req held 4 cycles with stable addr 0x300, be = 0010, wdata = 0xABAB_ABAB. After rvalid, reg_we_o = 0.
- LW at 0x402 → no req, misaligned_o pulse, valid_o = 1, reg_we_o = 0, no stall.
- Assert rst_n low during WAIT_RVALID → outputs 0 immediately. An rvalid after release is ignored; the next ADD completes normally.
